ckt: RTL and testbench
======================

CKT -- requirements
Module: ckt

Interface
REQ-001 SHALL have parameter LATENCY, default 3, meaning the number of clock cycles from input sampling to Y update; legal range 1 to 8.
REQ-002 SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit; reset is asynchronous and active-high.
REQ-004 SHALL have port A, input, 1 bit, logic operand.
REQ-005 SHALL have port B, input, 1 bit, logic operand.
REQ-006 SHALL have port C, input, 1 bit, logic operand.
REQ-007 SHALL have port D, input, 1 bit, logic operand.
REQ-008 SHALL have port E, input, 1 bit, logic operand.
REQ-009 SHALL have port F, input, 1 bit, logic operand.
REQ-010 SHALL have port Y, output, 1 bit, registered result of the logic function.

Function
REQ-011 SHALL compute the combinational function f = ((A OR B) AND (C XOR D)) OR (E AND F).
REQ-012 SHALL sample A–F on every rising clk edge while rst is low, with no enable or handshake.
REQ-013 SHALL implement a LATENCY-deep shift pipeline of f, so Y equals f of the inputs sampled exactly LATENCY rising edges earlier.
REQ-014 SHALL drive Y directly from the final pipeline register, with no combinational path from any input to Y.
REQ-015 SHALL capture every input change into the pipeline independently, including changes on consecutive cycles; intermediate values are never dropped or merged.
REQ-016 SHALL sample only the value present at the rising edge; input glitches between edges SHALL have no effect.
REQ-017 SHALL, when LATENCY = 1, update Y on the first rising edge after the inputs are sampled.
REQ-018 SHALL propagate an X or Z on any sampled input that affects f into the pipeline unchanged; no X-masking logic is added.

Reset
REQ-019 SHALL clear all pipeline stages and Y to 0 immediately on rst assertion, without waiting for a clock edge.
REQ-020 SHALL hold Y and all stages at 0 while rst is high, regardless of clk and inputs.
REQ-021 SHALL resume sampling on the first rising edge after rst deasserts; Y SHALL remain 0 for the following LATENCY−1 edges and then show f of that first sample.
REQ-022 SHALL discard all in-flight samples if rst asserts mid-operation; none of them SHALL appear on Y afterwards.

Verification
REQ-023 Reset check: assert rst with A=1, B=0, C=0, D=1, E=0, F=0 for 2 cycles -> Y=0 immediately and throughout.
REQ-024 Basic vector (LATENCY=3): rst low; apply A=1, B=0, C=0, D=1, E=0, F=0 -> Y=1 on the 3rd edge after sampling, and Y=0 before that.
REQ-025 Zero vector: apply A=0, B=0, C=1, D=1, E=0, F=0 -> Y=0 three edges after sampling.
REQ-026 Back-to-back sequence: vector 1, then vector 2, then vector 1 again on consecutive edges -> Y shows 1, 0, 1 on consecutive edges starting 3 edges after the first sample.
REQ-027 E/F term and full sweep:
- A=0, B=0, C=0, D=0, E=1, F=1 -> Y=1.
- Sweep all 64 input combinations against a reference model of f, delayed by LATENCY cycles -> zero mismatches.
REQ-028 Mid-stream reset: assert rst asynchronously between edges while 1s are in flight -> Y=0 at once and no stale 1 after release; repeat with LATENCY=1 -> Y follows f with 1-cycle delay.

Source files
------------

// File: rtl/ckt.sv
// ckt: registered 6-input logic function f = ((A|B) & (C^D)) | (E&F),
// delayed through a LATENCY-deep shift pipeline. Y comes straight from the last stage.
module ckt #(
   parameter int unsigned LATENCY = 3
) (
   input  logic clk,
   input  logic rst,
   input  logic A,
   input  logic B,
   input  logic C,
   input  logic D,
   input  logic E,
   input  logic F,
   output logic Y
);

   logic                 w_f;
   logic [LATENCY-1:0]   r_pipe;

   // X/Z on an input flows into the pipeline as-is; there is no masking.
   assign w_f = ((A | B) & (C ^ D)) | (E & F);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_pipe <= '0;
      end else begin
         r_pipe[0] <= w_f;
         for (int i = 1; i < int'(LATENCY); i++) begin
            r_pipe[i] <= r_pipe[i-1];
         end
      end
   end

   assign Y = r_pipe[LATENCY-1];

endmodule

// File: tb/tb_ckt.sv
// Bench for ckt: LATENCY=3 and LATENCY=1 instances share inputs and are checked
// against a sample-history model of f with directed, swept and random vectors.
module tb_ckt;

   logic clk;
   logic rst;
   logic A, B, C, D, E, F;
   logic w_y3;
   logic w_y1;

   int   n_checks = 0;
   int   n_fail   = 0;
   bit   hist[$];

   ckt #(.LATENCY(3)) dut3 (
      .clk(clk), .rst(rst), .A(A), .B(B), .C(C), .D(D), .E(E), .F(F), .Y(w_y3)
   );

   ckt #(.LATENCY(1)) dut1 (
      .clk(clk), .rst(rst), .A(A), .B(B), .C(C), .D(D), .E(E), .F(F), .Y(w_y1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // v = {A,B,C,D,E,F}
   function automatic bit fref(input logic [5:0] v);
      bit a, b, c, d, e, f;
      {a, b, c, d, e, f} = v;
      return ((a || b) && (c != d)) || (e && f);
   endfunction

   // Y equals f of the sample taken L edges ago, or 0 if fewer than L samples since reset.
   function automatic logic expect_y(input int l);
      if (hist.size() < l) return 1'b0;
      return hist[hist.size() - l];
   endfunction

   task automatic chk(input string tag, input logic obs, input logic exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic check_model(input string tag);
      chk({tag, "_L3"}, w_y3, expect_y(3));
      chk({tag, "_L1"}, w_y1, expect_y(1));
   endtask

   // Drive a vector, optionally glitch between edges, clock it in, check 1 unit later.
   task automatic step(input logic [5:0] v, input bit glitch, input string tag);
      {A, B, C, D, E, F} = v;
      if (glitch) begin
         #2;
         {A, B, C, D, E, F} = ~v;
         #1;
         {A, B, C, D, E, F} = v;
      end
      @(posedge clk);
      if (!rst) hist.push_back(fref(v));
      #1;
      check_model(tag);
   endtask

   localparam logic [5:0] V1   = 6'b100100;
   localparam logic [5:0] V2   = 6'b001100;
   localparam logic [5:0] VEF  = 6'b000011;
   localparam logic [5:0] VZ   = 6'b000000;

   initial begin
      rst = 1'b0;
      {A, B, C, D, E, F} = V1;
      #1;
      rst = 1'b1;
      #1;
      chk("reset_immediate_L3", w_y3, 1'b0);
      chk("reset_immediate_L1", w_y1, 1'b0);
      for (int i = 0; i < 2; i++) begin
         @(posedge clk);
         #1;
         chk("reset_hold_L3", w_y3, 1'b0);
         chk("reset_hold_L1", w_y1, 1'b0);
      end
      hist.delete();
      rst = 1'b0;

      // Back-to-back directed sequence with fixed expectations.
      step(V1, 1'b0, "b2b_e1");
      chk("basic_early_L3", w_y3, 1'b0);
      chk("basic_L1", w_y1, 1'b1);
      step(V2, 1'b0, "b2b_e2");
      chk("basic_early2_L3", w_y3, 1'b0);
      step(V1, 1'b0, "b2b_e3");
      chk("basic_L3", w_y3, 1'b1);
      step(VEF, 1'b0, "b2b_e4");
      chk("zero_vec_L3", w_y3, 1'b0);
      step(VZ, 1'b0, "b2b_e5");
      chk("b2b_third_L3", w_y3, 1'b1);
      step(VZ, 1'b0, "b2b_e6");
      chk("ef_term_L3", w_y3, 1'b1);
      step(VZ, 1'b0, "b2b_e7");
      chk("ef_tail_L3", w_y3, 1'b0);

      for (int i = 0; i < 64; i++) step(6'(i), 1'b0, "sweep");
      for (int i = 0; i < 3; i++) step(VZ, 1'b0, "sweep_flush");

      for (int i = 0; i < 200; i++) step(6'($urandom), 1'($urandom), "random");

      // Mid-stream asynchronous reset with ones in flight.
      step(V1, 1'b0, "load1");
      step(VEF, 1'b0, "load2");
      step(V1, 1'b0, "load3");
      #2;
      rst = 1'b1;
      #1;
      chk("midrst_now_L3", w_y3, 1'b0);
      chk("midrst_now_L1", w_y1, 1'b0);
      hist.delete();
      step(V1, 1'b0, "midrst_hold");
      #2;
      rst = 1'b0;
      step(V1, 1'b0, "post_rst_e1");
      step(VZ, 1'b0, "post_rst_e2");
      chk("post_rst_stale_L3", w_y3, 1'b0);
      step(VZ, 1'b0, "post_rst_e3");
      chk("post_rst_first_L3", w_y3, 1'b1);
      for (int i = 0; i < 40; i++) step(6'($urandom), 1'b0, "post_rst_rand");

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
